// File: rtl/addr_unit_arbiter_if.sv
// Bundle of signals between the two requesters, the arbiter and the shared address unit.
// The slave modport is the arbiter's view. The master modport is the clients' and address unit's view.
interface addr_unit_arbiter_if #(
  parameter int DW = 16
);
  logic          req0;
  logic          c0;
  logic          s0;
  logic [DW-1:0] d0;
  logic          req1;
  logic          c1;
  logic          s1;
  logic [DW-1:0] d1;
  logic          gnt0;
  logic          gnt1;
  logic          done0;
  logic          done1;
  logic [DW-1:0] addr_out;
  logic          busy;
  logic          dp_c;
  logic          dp_s;
  logic [DW-1:0] dp_d;
  logic [DW-1:0] dp_addr;

  modport slave (
    input  req0, c0, s0, d0,
    input  req1, c1, s1, d1,
    input  dp_addr,
    output gnt0, gnt1, done0, done1, addr_out, busy,
    output dp_c, dp_s, dp_d
  );

  modport master (
    output req0, c0, s0, d0,
    output req1, c1, s1, d1,
    output dp_addr,
    input  gnt0, gnt1, done0, done1, addr_out, busy,
    input  dp_c, dp_s, dp_d
  );
endinterface

// File: rtl/addr_unit_arbiter.sv
// Round-robin sequencer that shares one combinational address unit between two requesters.
// It holds the winner's operands on the unit for SETTLE cycles and then captures the result.
module addr_unit_arbiter #(
  parameter int DW     = 16,
  parameter int SETTLE = 2
) (
  input logic                clk,
  input logic                rst,
  addr_unit_arbiter_if.slave bus
);

  localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_DRIVE   = 2'd1,
    ST_CAPTURE = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          last_q, last_d;
  logic          gnt0_q, gnt0_d;
  logic          gnt1_q, gnt1_d;
  logic          done0_q, done0_d;
  logic          done1_q, done1_d;
  logic          busy_q, busy_d;
  logic          dp_c_q, dp_c_d;
  logic          dp_s_q, dp_s_d;
  logic [DW-1:0] dp_d_q, dp_d_d;
  logic [DW-1:0] addr_q, addr_d;

  logic          any_req_s;
  logic          pick1_s;

  // Requester 1 wins when it is alone, or when both request and 0 won the last contest.
  assign any_req_s = bus.req0 | bus.req1;
  assign pick1_s   = bus.req1 & (~bus.req0 | ~last_q);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (any_req_s) begin
          state_d = ST_DRIVE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_DRIVE: begin
        if (cnt_q == {CW{1'b0}}) begin
          state_d = ST_CAPTURE;
        end else begin
          state_d = ST_DRIVE;
        end
      end
      ST_CAPTURE: state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Output and datapath next values; every output leaves through a register
  always_comb begin
    cnt_d   = cnt_q;
    last_d  = last_q;
    gnt0_d  = gnt0_q;
    gnt1_d  = gnt1_q;
    done0_d = 1'b0;
    done1_d = 1'b0;
    busy_d  = busy_q;
    dp_c_d  = dp_c_q;
    dp_s_d  = dp_s_q;
    dp_d_d  = dp_d_q;
    addr_d  = addr_q;
    case (state_q)
      ST_IDLE: begin
        if (any_req_s) begin
          gnt0_d = ~pick1_s;
          gnt1_d = pick1_s;
          busy_d = 1'b1;
          dp_c_d = pick1_s ? bus.c1 : bus.c0;
          dp_s_d = pick1_s ? bus.s1 : bus.s0;
          dp_d_d = pick1_s ? bus.d1 : bus.d0;
          cnt_d  = CW'(SETTLE - 1);
          last_d = pick1_s;
        end else begin
          gnt0_d = 1'b0;
          gnt1_d = 1'b0;
          busy_d = 1'b0;
          dp_c_d = 1'b0;
          dp_s_d = 1'b0;
          dp_d_d = {DW{1'b0}};
        end
      end
      ST_DRIVE: begin
        // The unit inputs have now been stable for SETTLE cycles, so the result is captured on this edge.
        if (cnt_q == {CW{1'b0}}) begin
          done0_d = gnt0_q;
          done1_d = gnt1_q;
          addr_d  = bus.dp_addr;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      ST_CAPTURE: begin
        gnt0_d = 1'b0;
        gnt1_d = 1'b0;
        busy_d = 1'b0;
        dp_c_d = 1'b0;
        dp_s_d = 1'b0;
        dp_d_d = {DW{1'b0}};
      end
      default: begin
        gnt0_d = 1'b0;
        gnt1_d = 1'b0;
        busy_d = 1'b0;
        dp_c_d = 1'b0;
        dp_s_d = 1'b0;
        dp_d_d = {DW{1'b0}};
        cnt_d  = {CW{1'b0}};
      end
    endcase
  end

  // Output and datapath registers; last_q resets to 1 so that requester 0 wins the first contest
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= {CW{1'b0}};
      last_q  <= 1'b1;
      gnt0_q  <= 1'b0;
      gnt1_q  <= 1'b0;
      done0_q <= 1'b0;
      done1_q <= 1'b0;
      busy_q  <= 1'b0;
      dp_c_q  <= 1'b0;
      dp_s_q  <= 1'b0;
      dp_d_q  <= {DW{1'b0}};
      addr_q  <= {DW{1'b0}};
    end else begin
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      gnt0_q  <= gnt0_d;
      gnt1_q  <= gnt1_d;
      done0_q <= done0_d;
      done1_q <= done1_d;
      busy_q  <= busy_d;
      dp_c_q  <= dp_c_d;
      dp_s_q  <= dp_s_d;
      dp_d_q  <= dp_d_d;
      addr_q  <= addr_d;
    end
  end

  assign bus.gnt0     = gnt0_q;
  assign bus.gnt1     = gnt1_q;
  assign bus.done0    = done0_q;
  assign bus.done1    = done1_q;
  assign bus.busy     = busy_q;
  assign bus.dp_c     = dp_c_q;
  assign bus.dp_s     = dp_s_q;
  assign bus.dp_d     = dp_d_q;
  assign bus.addr_out = addr_q;

endmodule

// File: tb/tb_addr_unit_arbiter.sv
// Directed bench for addr_unit_arbiter. A stand-in address unit computes address = d ^ 16'h00FF.
module tb_addr_unit_arbiter;
  localparam int DW     = 16;
  localparam int SETTLE = 2;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_pass;
  int   both_cnt;
  int   n;
  int   extra;
  int   nz;

  addr_unit_arbiter_if #(.DW(DW)) bus ();

  addr_unit_arbiter #(.DW(DW), .SETTLE(SETTLE)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  assign bus.dp_addr = bus.dp_d ^ 16'h00FF;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Returns the number of negedges until a done pulse is seen, or -1 if the wait runs out.
  task automatic wait_done(input int start, output int cnt);
    cnt = start;
    do begin
      @(negedge clk);
      cnt++;
      if (bus.gnt0 && bus.gnt1) both_cnt++;
      if (bus.done0 && bus.done1) both_cnt++;
    end while (!(bus.done0 || bus.done1) && cnt < 40);
    if (!(bus.done0 || bus.done1)) cnt = -1;
  endtask

  task automatic pulse_reset;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    n_checks = 0; n_pass = 0; both_cnt = 0; nz = 0;
    rst = 1'b1;
    bus.req0 = 1'b0; bus.c0 = 1'b0; bus.s0 = 1'b0; bus.d0 = 16'h0000;
    bus.req1 = 1'b0; bus.c1 = 1'b0; bus.s1 = 1'b0; bus.d1 = 16'h0000;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // 1: idle after reset
    repeat (10) begin
      @(negedge clk);
      if (bus.busy || bus.gnt0 || bus.gnt1 || bus.done0 || bus.done1 ||
          bus.dp_c || bus.dp_s || (bus.dp_d != 16'h0000) || (bus.addr_out != 16'h0000)) nz++;
    end
    chk("t1_idle_nonzero", nz, 0);
    chk("t1_busy", bus.busy, 0);
    chk("t1_addr", bus.addr_out, 16'h0000);

    // 2: single request from requester 0
    bus.req0 = 1'b1; bus.c0 = 1'b0; bus.s0 = 1'b1; bus.d0 = 16'h0002;
    @(negedge clk);
    chk("t2_gnt", {bus.gnt0, bus.gnt1}, 2'b10);
    chk("t2_dp", {bus.dp_c, bus.dp_s, bus.dp_d}, {1'b0, 1'b1, 16'h0002});
    chk("t2_busy", bus.busy, 1);
    wait_done(1, n);
    chk("t2_latency", n, SETTLE + 1);
    chk("t2_done", {bus.done0, bus.done1, bus.gnt0}, 3'b101);
    chk("t2_addr", bus.addr_out, 16'h00FD);
    bus.req0 = 1'b0;
    @(negedge clk);
    chk("t2_after", {bus.done0, bus.gnt0, bus.busy, bus.dp_d}, {3'b000, 16'h0000});
    chk("t2_addr_hold", bus.addr_out, 16'h00FD);

    // 3: both requesting continuously, starting from a fresh contest
    pulse_reset();
    bus.req0 = 1'b1; bus.d0 = 16'h0004;
    bus.req1 = 1'b1; bus.d1 = 16'h0008;
    for (int k = 0; k < 4; k++) begin
      wait_done(0, n);
      if (k == 0) chk("t3_latency", n, SETTLE + 1);
      else        chk("t3_period", n, SETTLE + 2);
      chk("t3_who", {bus.done0, bus.done1}, (k % 2 == 0) ? 2'b10 : 2'b01);
      chk("t3_addr", bus.addr_out, (k % 2 == 0) ? 16'h00FB : 16'h00F7);
    end
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    repeat (3) @(negedge clk);
    chk("t3_idle", bus.busy, 0);
    chk("t3_mutex", both_cnt, 0);

    // 4: operand change after grant is ignored
    bus.req1 = 1'b1; bus.c1 = 1'b1; bus.s1 = 1'b0; bus.d1 = 16'h1234;
    @(negedge clk);
    chk("t4_gnt", {bus.gnt0, bus.gnt1}, 2'b01);
    chk("t4_dp", {bus.dp_c, bus.dp_s, bus.dp_d}, {1'b1, 1'b0, 16'h1234});
    bus.d1 = 16'hFFFF; bus.c1 = 1'b0;
    @(negedge clk);
    chk("t4_dp_stable", {bus.dp_c, bus.dp_d}, {1'b1, 16'h1234});
    wait_done(2, n);
    chk("t4_latency", n, SETTLE + 1);
    chk("t4_addr", bus.addr_out, 16'h12CB);
    bus.req1 = 1'b0;
    repeat (2) @(negedge clk);

    // 5: reset in the middle of DRIVE, then a contest immediately after release
    bus.req0 = 1'b1; bus.d0 = 16'h0F0F;
    @(negedge clk);
    chk("t5_gnt", bus.gnt0, 1);
    rst = 1'b1;
    bus.req1 = 1'b1; bus.d1 = 16'h00F0;
    #1;
    chk("t5_rst_outs", {bus.gnt0, bus.gnt1, bus.busy, bus.done0, bus.dp_c, bus.dp_s, bus.dp_d},
        {6'b000000, 16'h0000});
    chk("t5_rst_addr", bus.addr_out, 16'h0000);
    @(negedge clk);
    chk("t5_no_done", {bus.done0, bus.done1}, 2'b00);
    rst = 1'b0;
    @(negedge clk);
    chk("t5_winner", {bus.gnt0, bus.gnt1}, 2'b10);
    wait_done(1, n);
    chk("t5_latency", n, SETTLE + 1);
    chk("t5_done", {bus.done0, bus.done1}, 2'b10);
    chk("t5_addr", bus.addr_out, 16'h0FF0);
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    repeat (3) @(negedge clk);

    // 6: requester drops req during DRIVE
    bus.req0 = 1'b1; bus.d0 = 16'h5555;
    @(negedge clk);
    chk("t6_gnt", bus.gnt0, 1);
    bus.req0 = 1'b0;
    wait_done(1, n);
    chk("t6_latency", n, SETTLE + 1);
    chk("t6_done", {bus.done0, bus.done1}, 2'b10);
    chk("t6_addr", bus.addr_out, 16'h55AA);
    extra = 0;
    repeat (6) begin
      @(negedge clk);
      if (bus.done0 || bus.done1 || bus.busy) extra++;
    end
    chk("t6_idle_after", extra, 0);
    chk("t6_addr_hold", bus.addr_out, 16'h55AA);
    chk("mutex_all", both_cnt, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
